// File: rtl/sumdiff_decoder.sv
// sumdiff_decoder: recovers A and B from an encoded sum S = A+B and
// difference D = A-B, computing A = (S+D)/2 and B = (S-D)/2 bit-serially,
// LSB first, with one add slice and one subtract slice.
// Optional feature macro: SUMDIFF_RANGE_CHECK_EN adds the range_err output.
module sumdiff_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   s_in,
  input  logic [WIDTH:0]   d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             parity_err
`ifdef SUMDIFF_RANGE_CHECK_EN
  ,
  output logic             range_err
`endif
);

  // Internal arithmetic width: two guard bits so T and U never overflow.
  localparam int EW = WIDTH + 3;
  localparam int CW = $clog2(EW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0]    sSh_q, sSh_d;
  logic [EW-1:0]    dSh_q, dSh_d;
  logic             addCarry_q, addCarry_d;
  logic             subCarry_q, subCarry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tSh_q, tSh_d;
  logic [WIDTH-1:0] uSh_q, uSh_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             parity_q, parity_d;
`ifdef SUMDIFF_RANGE_CHECK_EN
  logic             rangeAcc_q, rangeAcc_d;
  logic             rangeErr_q, rangeErr_d;
`endif

  logic sBit, dBit, dInv;
  logic tBit, uBit;
  logic addCarryNext, subCarryNext;
  logic lastBit, midBit;

  // Full-adder slices: T = S + D and U = S + ~D + 1, one bit per cycle.
  always_comb begin
    sBit         = sSh_q[0];
    dBit         = dSh_q[0];
    dInv         = ~dBit;
    tBit         = sBit ^ dBit ^ addCarry_q;
    addCarryNext = (sBit & dBit) | (sBit & addCarry_q) | (dBit & addCarry_q);
    uBit         = sBit ^ dInv ^ subCarry_q;
    subCarryNext = (sBit & dInv) | (sBit & subCarry_q) | (dInv & subCarry_q);
    lastBit      = (cnt_q == CW'(EW - 1));
    midBit       = (cnt_q != '0) && (cnt_q <= CW'(WIDTH));
  end

  // Next-state and datapath updates; bit 0 of each result is dropped (the /2)
  // and only bits 1..WIDTH are shifted into the result registers.
  always_comb begin
    state_d    = state_q;
    sSh_d      = sSh_q;
    dSh_d      = dSh_q;
    addCarry_d = addCarry_q;
    subCarry_d = subCarry_q;
    cnt_d      = cnt_q;
    tSh_d      = tSh_q;
    uSh_d      = uSh_q;
    a_d        = a_q;
    b_d        = b_q;
    parity_d   = parity_q;
`ifdef SUMDIFF_RANGE_CHECK_EN
    rangeAcc_d = rangeAcc_q;
    rangeErr_d = rangeErr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = BUSY;
          sSh_d      = {2'b00, s_in};
          dSh_d      = {{2{d_in[WIDTH]}}, d_in};
          addCarry_d = 1'b0;
          subCarry_d = 1'b1;
          parity_d   = s_in[0] ^ d_in[0];
          cnt_d      = '0;
`ifdef SUMDIFF_RANGE_CHECK_EN
          rangeAcc_d = 1'b0;
`endif
        end
      end
      BUSY: begin
        sSh_d      = sSh_q >> 1;
        dSh_d      = dSh_q >> 1;
        addCarry_d = addCarryNext;
        subCarry_d = subCarryNext;
        cnt_d      = cnt_q + CW'(1);
        if (midBit) begin
          tSh_d = {tBit, tSh_q[WIDTH-1:1]};
          uSh_d = {uBit, uSh_q[WIDTH-1:1]};
        end
`ifdef SUMDIFF_RANGE_CHECK_EN
        if (!midBit && (cnt_q != '0)) begin
          rangeAcc_d = rangeAcc_q | tBit | uBit;
        end
`endif
        if (lastBit) begin
          state_d = DONE;
          a_d     = tSh_q;
          b_d     = uSh_q;
`ifdef SUMDIFF_RANGE_CHECK_EN
          rangeErr_d = rangeAcc_q | tBit | uBit;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: shifters, carries, counter and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sSh_q      <= '0;
      dSh_q      <= '0;
      addCarry_q <= 1'b0;
      subCarry_q <= 1'b0;
      cnt_q      <= '0;
      tSh_q      <= '0;
      uSh_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      parity_q   <= 1'b0;
`ifdef SUMDIFF_RANGE_CHECK_EN
      rangeAcc_q <= 1'b0;
      rangeErr_q <= 1'b0;
`endif
    end else begin
      sSh_q      <= sSh_d;
      dSh_q      <= dSh_d;
      addCarry_q <= addCarry_d;
      subCarry_q <= subCarry_d;
      cnt_q      <= cnt_d;
      tSh_q      <= tSh_d;
      uSh_q      <= uSh_d;
      a_q        <= a_d;
      b_q        <= b_d;
      parity_q   <= parity_d;
`ifdef SUMDIFF_RANGE_CHECK_EN
      rangeAcc_q <= rangeAcc_d;
      rangeErr_q <= rangeErr_d;
`endif
    end
  end

  assign in_ready   = rst_n && (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign a_out      = a_q;
  assign b_out      = b_q;
  assign parity_err = parity_q;
`ifdef SUMDIFF_RANGE_CHECK_EN
  assign range_err  = rangeErr_q;
`endif

endmodule

// File: tb/tb_sumdiff_decoder.sv
// Self-checking bench for sumdiff_decoder using a scoreboard of expected
// results derived from A = (S+D)/2, B = (S-D)/2 at full precision.
module tb_sumdiff_decoder;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         par;
    logic         rng;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   s_in;
  logic [W:0]   d_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         parity_err;
`ifdef SUMDIFF_RANGE_CHECK_EN
  logic         range_err;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  sumdiff_decoder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .s_in       (s_in),
    .d_in       (d_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_out      (a_out),
    .b_out      (b_out),
`ifdef SUMDIFF_RANGE_CHECK_EN
    .range_err  (range_err),
`endif
    .parity_err (parity_err)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: full-precision sum and difference, then drop bit 0.
  function automatic exp_t model(input logic [W:0] s, input logic [W:0] d);
    logic [W+2:0] se, de, t, u;
    exp_t e;
    se    = {2'b00, s};
    de    = {{2{d[W]}}, d};
    t     = se + de;
    u     = se - de;
    e.a   = t[W:1];
    e.b   = u[W:1];
    e.par = s[0] ^ d[0];
    e.rng = (t[W+2:W+1] != 2'b00) || (u[W+2:W+1] != 2'b00);
    return e;
  endfunction

  // Drive one pair at a negedge and hold it across the accepting edge.
  task automatic applyStimulus(input logic [W:0] s, input logic [W:0] d, input bit push);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("[TB] FAIL accept_timeout: in_ready got 0 required 1");
    end
    in_valid = 1'b1;
    s_in     = s;
    d_in     = d;
    if (push) sb.push_back(model(s, d));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid rises (bounded).
  task automatic waitOutValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    d_in      = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (a_out !== '0 || b_out !== '0) begin errors++; $display("[TB] FAIL reset_ab: got %0d/%0d required 0/0", a_out, b_out); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity: got %b required 0", parity_err); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_decode();
    logic [W:0] sTab[5] = '{5'd14, 5'd15, 5'b00011, 5'd0, 5'd30};
    logic [W:0] dTab[5] = '{5'd4, 5'b10111, 5'd0, 5'd2, 5'd0};
    logic [W:0] s, d;
    int lat;
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      if (i < 5) begin
        s = sTab[i];
        d = dTab[i];
      end else if (i < 8) begin
        logic [W:0] av, bv;
        av = W'($urandom_range(0, 15));
        bv = W'($urandom_range(0, 15));
        s  = av + bv;
        d  = av - bv;
      end else begin
        s = (W+1)'($urandom);
        d = (W+1)'($urandom);
      end
      applyStimulus(s, d, 1'b1);
      waitOutValid(lat);
      checks++; if (lat !== W + 3) begin errors++; $display("[TB] FAIL latency[%0d]: got %0d required %0d", i, lat, W + 3); end
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("[TB] FAIL scoreboard_empty[%0d]: got 0 entries required 1", i);
        continue;
      end
      e = sb.pop_front();
      checks++; if (a_out !== e.a) begin errors++; $display("[TB] FAIL a_out[%0d] s=%0d d=%0d: got %0d required %0d", i, s, d, a_out, e.a); end
      checks++; if (b_out !== e.b) begin errors++; $display("[TB] FAIL b_out[%0d] s=%0d d=%0d: got %0d required %0d", i, s, d, b_out, e.b); end
      checks++; if (parity_err !== e.par) begin errors++; $display("[TB] FAIL parity_err[%0d]: got %b required %b", i, parity_err, e.par); end
`ifdef SUMDIFF_RANGE_CHECK_EN
      checks++; if (range_err !== e.rng) begin errors++; $display("[TB] FAIL range_err[%0d]: got %b required %b", i, range_err, e.rng); end
`endif
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL handshake[%0d]: got valid=%b ready=%b required 0/1", i, out_valid, in_ready); end
      checks++; if (a_out !== e.a || b_out !== e.b) begin errors++; $display("[TB] FAIL hold_after_ack[%0d]: got %0d/%0d required %0d/%0d", i, a_out, b_out, e.a, e.b); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    applyStimulus(5'd20, 5'd6, 1'b1);
    waitOutValid(lat);
    checks++; if (lat !== W + 3) begin errors++; $display("[TB] FAIL bp_latency: got %0d required %0d", lat, W + 3); end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      s_in     = 5'd3;
      d_in     = 5'd1;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_state[%0d]: got valid=%b ready=%b required 1/0", k, out_valid, in_ready); end
      checks++; if (a_out !== e.a || b_out !== e.b) begin errors++; $display("[TB] FAIL bp_hold_data[%0d]: got %0d/%0d required %0d/%0d", k, a_out, b_out, e.a, e.b); end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got valid=%b ready=%b required 0/1", out_valid, in_ready); end
    applyStimulus(5'd9, 5'b11111, 1'b1);
    waitOutValid(lat);
    e = sb.pop_front();
    checks++; if (lat !== W + 3) begin errors++; $display("[TB] FAIL bp_next_latency: got %0d required %0d", lat, W + 3); end
    checks++; if (a_out !== e.a || b_out !== e.b || parity_err !== e.par) begin errors++; $display("[TB] FAIL bp_next_data: got %0d/%0d/%b required %0d/%0d/%b", a_out, b_out, parity_err, e.a, e.b, e.par); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen = 0;
    exp_t e;
    applyStimulus(5'b00011, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_state: got valid=%b ready=%b required 0/0", out_valid, in_ready); end
    checks++; if (a_out !== '0 || b_out !== '0 || parity_err !== 1'b0) begin errors++; $display("[TB] FAIL abort_outputs: got %0d/%0d/%b required 0/0/0", a_out, b_out, parity_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle: got ready=%b required 1", in_ready); end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_valid: got %0d valid cycles required 0", seen); end
    applyStimulus(5'd22, 5'd4, 1'b1);
    waitOutValid(lat);
    e = sb.pop_front();
    checks++; if (lat !== W + 3) begin errors++; $display("[TB] FAIL fresh_latency: got %0d required %0d", lat, W + 3); end
    checks++; if (a_out !== e.a || b_out !== e.b || parity_err !== e.par) begin errors++; $display("[TB] FAIL fresh_data: got %0d/%0d/%b required %0d/%0d/%b", a_out, b_out, parity_err, e.a, e.b, e.par); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_reset_abort();
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
